// File: rtl/root_round_controller.sv
// root_round_controller
// Round sequencer for the root hub of the multi-FPGA union-find decoder.
// A round is LOAD, then one or more GROW commands, then RESULT. After every
// GROW the controller waits for the children to go quiet. It then either
// finishes the round, grows again, or gives up and reports a deadlock.
//
// Ports:
//   clk                            system clock
//   reset                          synchronous, active-high reset
//   new_round_start                single-cycle request to start a round
//   cmd_data[1:0]                  command: 0=LOAD, 1=GROW, 2=RESULT
//   cmd_valid / cmd_ready          valid/ready handshake for cmd_data
//   downstream_has_message_flying  per-child messages-in-flight flags
//   downstream_has_odd_clusters    per-child odd-cluster flags
//   result_valid                   round finished normally (sticky)
//   deadlock                       round aborted (sticky)
//   iteration_counter              GROW commands accepted this round
//   cycle_counter                  active cycles this round
//   busy                           round in progress
module root_round_controller #(
    parameter int NUM_CHILDREN            = 2,
    parameter int ITERATION_COUNTER_WIDTH = 8,
    parameter int MAX_ITERATIONS          = 16,
    parameter int QUIET_CYCLES            = 3,
    parameter int DEADLOCK_CYCLES         = 4096
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               new_round_start,
    output logic [1:0]                         cmd_data,
    output logic                               cmd_valid,
    input  logic                               cmd_ready,
    input  logic [NUM_CHILDREN-1:0]            downstream_has_message_flying,
    input  logic [NUM_CHILDREN-1:0]            downstream_has_odd_clusters,
    output logic                               result_valid,
    output logic                               deadlock,
    output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
    output logic [31:0]                        cycle_counter,
    output logic                               busy
);

    localparam int ICW = ITERATION_COUNTER_WIDTH;
    // quiet_cnt never exceeds QUIET_CYCLES: it either exits or clears first.
    localparam int QW  = (QUIET_CYCLES < 2) ? 1 : $clog2(QUIET_CYCLES + 1);

    localparam logic [1:0]     CMD_LOAD   = 2'd0;
    localparam logic [1:0]     CMD_GROW   = 2'd1;
    localparam logic [1:0]     CMD_RESULT = 2'd2;
    localparam logic [QW-1:0]  QUIET_LAST = QW'(QUIET_CYCLES - 1);
    localparam logic [31:0]    TIMEOUT_AT = 32'(DEADLOCK_CYCLES - 1);
    localparam logic [ICW-1:0] ITER_CAP   = ICW'(MAX_ITERATIONS);
    localparam logic [ICW-1:0] ITER_SAT   = {ICW{1'b1}};
    localparam logic [31:0]    CYC_SAT    = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SEND_LOAD   = 3'd1,
        ST_SEND_GROW   = 3'd2,
        ST_WAIT_QUIET  = 3'd3,
        ST_SEND_RESULT = 3'd4,
        ST_DONE        = 3'd5,
        ST_DEADLOCK    = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [QW-1:0]    quiet_cnt_q, quiet_cnt_d;
    logic [ICW-1:0]   iter_q, iter_d;
    logic [31:0]      cyc_q, cyc_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [1:0]       cmd_data_q, cmd_data_d;
    logic             result_valid_q, result_valid_d;
    logic             deadlock_q, deadlock_d;
    logic             busy_q, busy_d;

    logic             active_s;
    logic             xfer_s;
    logic             start_s;
    logic             timeout_s;
    logic             any_flying_s;
    logic             any_odd_s;

    function automatic logic is_active(input state_t s);
        case (s)
            ST_SEND_LOAD, ST_SEND_GROW, ST_WAIT_QUIET, ST_SEND_RESULT: return 1'b1;
            default:                                                  return 1'b0;
        endcase
    endfunction

    assign active_s     = is_active(state_q);
    // cmd_valid_q is high exactly in the SEND_* states, so this is a transfer.
    assign xfer_s       = cmd_valid_q & cmd_ready;
    assign start_s      = ~active_s & new_round_start;
    assign timeout_s    = active_s & (cyc_q == TIMEOUT_AT);
    assign any_flying_s = |downstream_has_message_flying;
    assign any_odd_s    = |downstream_has_odd_clusters;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            quiet_cnt_q    <= '0;
            iter_q         <= '0;
            cyc_q          <= 32'd0;
            cmd_valid_q    <= 1'b0;
            cmd_data_q     <= CMD_LOAD;
            result_valid_q <= 1'b0;
            deadlock_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            quiet_cnt_q    <= quiet_cnt_d;
            iter_q         <= iter_d;
            cyc_q          <= cyc_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_data_q     <= cmd_data_d;
            result_valid_q <= result_valid_d;
            deadlock_q     <= deadlock_d;
            busy_q         <= busy_d;
        end
    end

    // Next-state logic; the cycle budget overrides everything, including a handshake
    always_comb begin
        state_d = state_q;
        if (timeout_s) begin
            state_d = ST_DEADLOCK;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_DEADLOCK: begin
                    if (start_s) state_d = ST_SEND_LOAD;
                    else         state_d = state_q;
                end
                ST_SEND_LOAD: begin
                    if (xfer_s) state_d = ST_SEND_GROW;
                    else        state_d = state_q;
                end
                ST_SEND_GROW: begin
                    if (xfer_s) state_d = ST_WAIT_QUIET;
                    else        state_d = state_q;
                end
                ST_WAIT_QUIET: begin
                    // Odd clusters are only looked at once the window has filled.
                    if (!any_flying_s && (quiet_cnt_q == QUIET_LAST)) begin
                        if (!any_odd_s)              state_d = ST_SEND_RESULT;
                        else if (iter_q == ITER_CAP) state_d = ST_DEADLOCK;
                        else                         state_d = ST_SEND_GROW;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_SEND_RESULT: begin
                    if (xfer_s) state_d = ST_DONE;
                    else        state_d = state_q;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Round counters: iteration count, active-cycle count and quiet window
    always_comb begin
        iter_d      = iter_q;
        cyc_d       = cyc_q;
        quiet_cnt_d = quiet_cnt_q;
        if (start_s) begin
            iter_d = '0;
            cyc_d  = 32'd0;
        end else if (active_s) begin
            if (cyc_q != CYC_SAT) cyc_d = cyc_q + 32'd1;
            else                  cyc_d = cyc_q;
            // A GROW accepted in the timeout cycle counts as dropped.
            if (timeout_s) begin
                iter_d = iter_q;
            end else if ((state_q == ST_SEND_GROW) && xfer_s) begin
                if (iter_q != ITER_SAT) iter_d = iter_q + ICW'(1);
                else                    iter_d = iter_q;
                quiet_cnt_d = '0;
            end else if (state_q == ST_WAIT_QUIET) begin
                if (any_flying_s) quiet_cnt_d = '0;
                else              quiet_cnt_d = quiet_cnt_q + QW'(1);
            end else begin
                quiet_cnt_d = quiet_cnt_q;
            end
        end else begin
            iter_d = iter_q;
        end
    end

    // Output decode of the next state so that every output is a flop
    always_comb begin
        cmd_valid_d    = 1'b0;
        cmd_data_d     = CMD_LOAD;
        result_valid_d = 1'b0;
        deadlock_d     = 1'b0;
        busy_d         = is_active(state_d);
        case (state_d)
            ST_SEND_LOAD: begin
                cmd_valid_d = 1'b1;
                cmd_data_d  = CMD_LOAD;
            end
            ST_SEND_GROW: begin
                cmd_valid_d = 1'b1;
                cmd_data_d  = CMD_GROW;
            end
            ST_SEND_RESULT: begin
                cmd_valid_d = 1'b1;
                cmd_data_d  = CMD_RESULT;
            end
            ST_DONE:     result_valid_d = 1'b1;
            ST_DEADLOCK: deadlock_d     = 1'b1;
            default: begin
                cmd_valid_d = 1'b0;
                cmd_data_d  = CMD_LOAD;
            end
        endcase
    end

    assign cmd_valid         = cmd_valid_q;
    assign cmd_data          = cmd_data_q;
    assign result_valid      = result_valid_q;
    assign deadlock          = deadlock_q;
    assign iteration_counter = iter_q;
    assign cycle_counter     = cyc_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_root_round_controller.sv
// Testbench for root_round_controller. Two instances share all inputs:
// dut_a uses the default parameters, dut_b uses MAX_ITERATIONS=2 and
// DEADLOCK_CYCLES=64. A per-cycle reference model shadows each instance.
module tb_root_round_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, nrs, rdy;
    logic [1:0] fly, odd;

    logic [1:0]  a_data, b_data;
    logic        a_valid, b_valid, a_rv, b_rv, a_dl, b_dl, a_busy, b_busy;
    logic [7:0]  a_iter, b_iter;
    logic [31:0] a_cyc, b_cyc;

    root_round_controller #(
        .NUM_CHILDREN(2), .ITERATION_COUNTER_WIDTH(8), .MAX_ITERATIONS(16),
        .QUIET_CYCLES(3), .DEADLOCK_CYCLES(4096)
    ) dut_a (
        .clk(clk), .reset(reset), .new_round_start(nrs),
        .cmd_data(a_data), .cmd_valid(a_valid), .cmd_ready(rdy),
        .downstream_has_message_flying(fly), .downstream_has_odd_clusters(odd),
        .result_valid(a_rv), .deadlock(a_dl), .iteration_counter(a_iter),
        .cycle_counter(a_cyc), .busy(a_busy)
    );

    root_round_controller #(
        .NUM_CHILDREN(2), .ITERATION_COUNTER_WIDTH(8), .MAX_ITERATIONS(2),
        .QUIET_CYCLES(3), .DEADLOCK_CYCLES(64)
    ) dut_b (
        .clk(clk), .reset(reset), .new_round_start(nrs),
        .cmd_data(b_data), .cmd_valid(b_valid), .cmd_ready(rdy),
        .downstream_has_message_flying(fly), .downstream_has_odd_clusters(odd),
        .result_valid(b_rv), .deadlock(b_dl), .iteration_counter(b_iter),
        .cycle_counter(b_cyc), .busy(b_busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    localparam int P_IDLE = 0, P_LOAD = 1, P_GROW = 2, P_WAIT = 3,
                   P_RESULT = 4, P_DONE = 5, P_DEAD = 6;
    localparam int QUIET = 3;

    typedef struct {
        int     ph;
        int     it;
        longint cy;
        int     qc;
    } mdl_t;

    mdl_t ma = '{P_IDLE, 0, 0, 0};
    mdl_t mb = '{P_IDLE, 0, 0, 0};

    function automatic mdl_t mstep(input mdl_t m, input logic rst, input logic start,
                                   input logic rdy_i, input logic [1:0] f,
                                   input logic [1:0] o, input int maxit, input int dlc);
        mdl_t n;
        bit   act;
        n = m;
        if (rst) begin
            n.ph = P_IDLE; n.it = 0; n.cy = 0; n.qc = 0;
            return n;
        end
        act = (m.ph >= P_LOAD) && (m.ph <= P_RESULT);
        if (!act) begin
            if (start) begin
                n.ph = P_LOAD; n.it = 0; n.cy = 0;
            end
            return n;
        end
        if (m.cy < 64'hFFFF_FFFF) n.cy = m.cy + 1;
        if (m.cy == longint'(dlc - 1)) begin
            n.ph = P_DEAD;
            return n;
        end
        case (m.ph)
            P_LOAD:   if (rdy_i) n.ph = P_GROW;
            P_GROW:   if (rdy_i) begin
                          n.ph = P_WAIT;
                          n.it = (m.it < 255) ? m.it + 1 : 255;
                          n.qc = 0;
                      end
            P_WAIT:   if (f != 2'b00) n.qc = 0;
                      else begin
                          n.qc = m.qc + 1;
                          if (m.qc == QUIET - 1)
                              n.ph = (o == 2'b00) ? P_RESULT
                                   : ((m.it == maxit) ? P_DEAD : P_GROW);
                      end
            P_RESULT: if (rdy_i) n.ph = P_DONE;
            default:  n.ph = m.ph;
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        ma = mstep(ma, reset, nrs, rdy, fly, odd, 16, 4096);
        mb = mstep(mb, reset, nrs, rdy, fly, odd, 2, 64);
    end

    task automatic mcheck(input string tag, input mdl_t m, input logic v,
                          input logic [1:0] d, input logic rv, input logic dl,
                          input logic bz, input logic [7:0] it, input logic [31:0] cy);
        logic       ev, erv, edl, ebz;
        logic [1:0] ed;
        ev  = (m.ph == P_LOAD) || (m.ph == P_GROW) || (m.ph == P_RESULT);
        ed  = (m.ph == P_GROW) ? 2'd1 : ((m.ph == P_RESULT) ? 2'd2 : 2'd0);
        erv = (m.ph == P_DONE);
        edl = (m.ph == P_DEAD);
        ebz = (m.ph >= P_LOAD) && (m.ph <= P_RESULT);
        vectors++;
        if ({v, d, rv, dl, bz, it, cy} !== {ev, ed, erv, edl, ebz, 8'(m.it), 32'(m.cy)}) begin
            miscompares++;
            $display("FAIL model_%s t=%0t: got v=%b d=%0d rv=%b dl=%b busy=%b it=%0d cyc=%0d, expected v=%b d=%0d rv=%b dl=%b busy=%b it=%0d cyc=%0d",
                     tag, $time, v, d, rv, dl, bz, it, cy, ev, ed, erv, edl, ebz, m.it, m.cy);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Advance one clock and compare both instances against the model.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        mcheck("a", ma, a_valid, a_data, a_rv, a_dl, a_busy, a_iter, a_cyc);
        mcheck("b", mb, b_valid, b_data, b_rv, b_dl, b_busy, b_iter, b_cyc);
    endtask

    // ---------------- directed clean-round table ----------------
    typedef struct {
        logic        nrs;
        logic [1:0]  e_data;
        logic        e_valid;
        logic        e_rv;
        logic        e_dl;
        logic        e_busy;
        logic [7:0]  e_it;
        logic [31:0] e_cy;
    } vec_t;

    vec_t tab [9];

    initial begin
        int grows;
        int cnt;
        logic [31:0] prev_cyc;

        tab[0] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0};
        tab[1] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 32'd0};
        tab[2] = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 32'd1};
        tab[3] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 32'd2};
        tab[4] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 32'd3};
        tab[5] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 32'd4};
        tab[6] = '{1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 32'd5};
        tab[7] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 32'd6};
        tab[8] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 32'd6};

        reset = 1'b1; nrs = 1'b0; rdy = 1'b1; fly = 2'b00; odd = 2'b00;
        next_cycle();
        next_cycle();
        chk("reset_a", {a_data, a_valid, a_rv, a_dl, a_busy, a_iter, a_cyc}, 64'd0);
        chk("reset_b", {b_data, b_valid, b_rv, b_dl, b_busy, b_iter, b_cyc}, 64'd0);
        reset = 1'b0;
        next_cycle();

        // Clean round, cycle by cycle
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("clean[%0d].a", i),
                {a_data, a_valid, a_rv, a_dl, a_busy, a_iter, a_cyc},
                {tab[i].e_data, tab[i].e_valid, tab[i].e_rv, tab[i].e_dl,
                 tab[i].e_busy, tab[i].e_it, tab[i].e_cy});
            chk($sformatf("clean[%0d].b", i),
                {b_data, b_valid, b_rv, b_dl, b_busy, b_iter, b_cyc},
                {tab[i].e_data, tab[i].e_valid, tab[i].e_rv, tab[i].e_dl,
                 tab[i].e_busy, tab[i].e_it, tab[i].e_cy});
            nrs = tab[i].nrs;
            next_cycle();
        end

        // Multi-iteration: odd clusters through two windows; dut_b hits its cap
        odd = 2'b10; nrs = 1'b1;
        next_cycle();
        nrs = 1'b0; grows = 0;
        for (int c = 0; c < 200 && !a_rv; c++) begin
            if (a_valid && (a_data == 2'd1) && rdy) begin
                grows++;
                if (grows == 3) odd = 2'b00;
            end
            next_cycle();
        end
        chk("multi_rv_a", a_rv, 1);
        chk("multi_grows_a", grows, 3);
        chk("multi_iter_a", a_iter, 3);
        chk("multi_dl_a", a_dl, 0);
        chk("itercap_dl_b", b_dl, 1);
        chk("itercap_iter_b", b_iter, 2);
        chk("itercap_rv_b", b_rv, 0);

        // Backpressure during SEND_LOAD
        rdy = 1'b0; nrs = 1'b1;
        next_cycle();
        nrs = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("bp_hold[%0d]", j), {a_valid, a_data, a_cyc}, {1'b1, 2'd0, 32'(j)});
            next_cycle();
        end
        chk("bp_after5", {a_valid, a_data, a_cyc}, {1'b1, 2'd0, 32'd5});
        rdy = 1'b1;
        next_cycle();
        chk("bp_grow", {a_valid, a_data}, {1'b1, 2'd1});
        for (int c = 0; c < 50 && !a_rv; c++) next_cycle();
        chk("bp_done_rv", a_rv, 1);
        chk("bp_done_cyc", a_cyc, 11);

        // Quiet restart: one flying cycle in the second quiet cycle
        nrs = 1'b1;
        next_cycle();             // cycle 1
        nrs = 1'b0;
        next_cycle();             // cycle 2
        next_cycle();             // cycle 3
        next_cycle();             // cycle 4
        fly = 2'b01;
        next_cycle();             // cycle 5
        fly = 2'b00;
        next_cycle();             // cycle 6
        chk("qr_no_result_c6", a_valid, 0);
        next_cycle();             // cycle 7
        chk("qr_no_result_c7", a_valid, 0);
        next_cycle();             // cycle 8
        chk("qr_result_c8", {a_valid, a_data}, {1'b1, 2'd2});
        next_cycle();             // cycle 9
        chk("qr_done", {a_rv, a_cyc}, {1'b1, 32'd8});

        // Timeout deadlock on dut_b with flying stuck
        fly = 2'b11; nrs = 1'b1;
        next_cycle();
        nrs = 1'b0; cnt = 1;
        while (!b_dl && cnt < 200) begin
            next_cycle();
            cnt++;
        end
        chk("to_cycle_index", cnt, 65);
        chk("to_dl_b", {b_dl, b_rv, b_busy, b_cyc}, {1'b1, 1'b0, 1'b0, 32'd64});

        // Start request: ignored by dut_a (WAIT_QUIET), accepted by dut_b
        prev_cyc = a_cyc;
        nrs = 1'b1;
        next_cycle();
        nrs = 1'b0;
        chk("ignore_a", {a_busy, a_valid, a_iter, a_cyc}, {1'b1, 1'b0, 8'd1, prev_cyc + 32'd1});
        chk("restart_b", {b_dl, b_busy, b_valid, b_data, b_cyc}, {1'b0, 1'b1, 1'b1, 2'd0, 32'd0});
        next_cycle();
        chk("b_in_grow", {b_valid, b_data}, {1'b1, 2'd1});

        // Reset in SEND_GROW
        reset = 1'b1;
        next_cycle();
        chk("midreset_a", {a_data, a_valid, a_rv, a_dl, a_busy, a_iter, a_cyc}, 64'd0);
        chk("midreset_b", {b_data, b_valid, b_rv, b_dl, b_busy, b_iter, b_cyc}, 64'd0);
        reset = 1'b0; fly = 2'b00;
        nrs = 1'b1;
        next_cycle();
        nrs = 1'b0;
        for (int c = 0; c < 50 && !a_rv; c++) next_cycle();
        chk("post_reset_a", {a_rv, a_iter, a_cyc}, {1'b1, 8'd1, 32'd6});
        chk("post_reset_b", {b_rv, b_iter}, {1'b1, 8'd1});

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            nrs   = ($urandom_range(0, 9) == 0);
            rdy   = ($urandom_range(0, 3) != 0);
            fly   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            odd   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/root_round_controller.md
Name: root_round_controller

Overview:
Round sequencer for the root hub of the multi-FPGA union-find decoder. On new_round_start it broadcasts a LOAD command to the children. It then repeats GROW commands until every child reports quiescence (no messages in flight) and no odd clusters remain. Finally it issues RESULT and raises result_valid. It supervises the downstream has_message_flying/has_odd_clusters flags, counts iterations and cycles, and flags deadlock on timeout or iteration overrun.

Parameters:
NUM_CHILDREN, 2, number of downstream children; width of the flag vectors
ITERATION_COUNTER_WIDTH, 8, width of iteration_counter
MAX_ITERATIONS, 16, GROW commands allowed before odd clusters are declared a deadlock
QUIET_CYCLES, 3, consecutive all-quiet cycles required before odd-cluster sampling (>=1)
DEADLOCK_CYCLES, 4096, active-cycle budget per round

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
new_round_start  input  1  single-cycle request to start decoding a round
cmd_data  output  2  command to downstream broadcaster: 0=LOAD, 1=GROW, 2=RESULT
cmd_valid  output  1  cmd_data valid
cmd_ready  input  1  broadcaster accepts cmd_data
downstream_has_message_flying  input  NUM_CHILDREN  per-child messages-in-flight flag
downstream_has_odd_clusters  input  NUM_CHILDREN  per-child odd-cluster flag
result_valid  output  1  round finished normally
deadlock  output  1  round aborted (timeout or iteration cap)
iteration_counter  output  ITERATION_COUNTER_WIDTH  GROW commands issued this round
cycle_counter  output  32  active cycles this round
busy  output  1  high in any state except IDLE, DONE, DEADLOCK

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset: state=IDLE; cmd_valid=0, cmd_data=0, result_valid=0, deadlock=0, busy=0, iteration_counter=0, cycle_counter=0, quiet_cnt=0.
- Reset mid-round aborts the round immediately, with no command completion.
- States: IDLE, SEND_LOAD, SEND_GROW, WAIT_QUIET, SEND_RESULT, DONE, DEADLOCK. All outputs are registered.
- IDLE/DONE/DEADLOCK with new_round_start=1: next state SEND_LOAD. Clear result_valid, deadlock, iteration_counter and cycle_counter.
- new_round_start in any other state is ignored.
- SEND_LOAD/SEND_GROW/SEND_RESULT: cmd_valid=1, cmd_data = 0/1/2 respectively.
- Handshake: a transfer occurs when cmd_valid & cmd_ready. cmd_data stays stable and cmd_valid stays high until the transfer.
- State advance on transfer:
  - SEND_LOAD -> SEND_GROW.
  - SEND_GROW -> WAIT_QUIET; iteration_counter +1, and quiet_cnt cleared.
  - SEND_RESULT -> DONE.
- cmd_valid drops the cycle after any transfer.
- WAIT_QUIET counting: if |downstream_has_message_flying, quiet_cnt <= 0; else quiet_cnt +1.
- WAIT_QUIET exit is evaluated only when quiet_cnt == QUIET_CYCLES-1 and all flying bits are 0 this cycle:
  - if |downstream_has_odd_clusters == 0 -> SEND_RESULT;
  - else if iteration_counter == MAX_ITERATIONS -> DEADLOCK;
  - else -> SEND_GROW.
- DONE: result_valid=1, held until the next accepted new_round_start. It clears on the same edge the round restarts.
- DEADLOCK: deadlock=1, held the same way. result_valid stays 0.
- cycle_counter: increments by 1 on every clock while in SEND_LOAD..SEND_RESULT. It is frozen in IDLE/DONE/DEADLOCK and saturates at 2^32-1.
- Timeout: in an active state, if cycle_counter == DEADLOCK_CYCLES-1, the next state is DEADLOCK. This has priority over all other transitions, including a simultaneous handshake, whose command is then considered dropped. cycle_counter reads DEADLOCK_CYCLES in DEADLOCK.
- iteration_counter saturates at all-ones; MAX_ITERATIONS must be less than 2^ITERATION_COUNTER_WIDTH.
- busy is a registered decode of state.

Test Plan:
- Clean round (QUIET_CYCLES=3, cmd_ready=1, flags=0; new_round_start at cycle 0):
  - LOAD transfers at cycle 1, GROW at cycle 2, RESULT at cycle 6.
  - result_valid=1 from cycle 7 with iteration_counter=1, cycle_counter=6, deadlock=0.
- Multi-iteration: downstream_has_odd_clusters=2'b10 through the first two quiet windows, then 0 -> three GROW transfers, iteration_counter=3, result_valid=1.
- Backpressure: cmd_ready=0 for 5 cycles during SEND_LOAD -> cmd_valid=1 and cmd_data=0 held stable, no state advance, cycle_counter increases by 5, then the normal sequence resumes.
- Quiet restart: flying=2'b01 for one cycle during the second quiet cycle -> quiet_cnt clears, RESULT is delayed by 2 cycles versus the clean round.
- Deadlock:
  - DEADLOCK_CYCLES=64 with flying stuck at 2'b11 -> deadlock=1 with cycle_counter=64 and result_valid=0; the next new_round_start clears deadlock.
  - Separately, MAX_ITERATIONS=2 with odd clusters stuck -> deadlock after iteration_counter=2.
- Reset/ignore:
  - new_round_start during WAIT_QUIET is ignored.
  - reset asserted in SEND_GROW -> next cycle all outputs 0 and state IDLE.
  - A subsequent clean round completes with iteration_counter=1.
